breakout_frame_ctrl: RTL and testbench
======================================

// Module: breakout_frame_ctrl
// PURPOSE
//  Frame controller sitting in front of the breakout-to-host DDR serializer.
//  - Generates the frame-load strobe, one cycle in every FRAME_CYCLES.
//  - Synchronizes and debounces the raw breakout inputs.
//  - Presents a coherent snapshot of port/button/link-power that is stable for
//    a whole frame.
//  - Handles start/stop of streaming (enable handshake) and counts frames.
// PARAMETERS
//  FRAME_CYCLES     5      i_clk cycles per frame (10 DDR bits / 2); legal >= 3
//  DEBOUNCE_CYCLES  1000   consecutive stable cycles before a button change is accepted; >= 1
//  CNT_W            16     width of o_frame_cnt
// PORTS
//  i_clk        in   1      serializer clock (0.5x data bit rate); sole clock
//  i_rst        in   1      synchronous, active-high reset
//  i_enable     in   1      request streaming; level-sensitive
//  i_port       in   8      raw digital-in pins (asynchronous)
//  i_button     in   6      raw button pins (asynchronous, bouncy)
//  i_link_pow   in   4      raw link-power status (asynchronous)
//  o_load       out  1      1-cycle strobe: serializer latches o_port/o_button/o_link_pow
//  o_phase      out  3      frame phase 0..FRAME_CYCLES-1 (0 in IDLE)
//  o_port       out  8      snapshot, synchronized digital-in
//  o_button     out  6      snapshot, debounced buttons
//  o_link_pow   out  4      snapshot, synchronized link power
//  o_active     out  1      1 while in ARM or RUN
//  o_frame_cnt  out  CNT_W  number of o_load strobes issued, wraps
// BEHAVIOUR
//  - Reset (i_rst=1 at posedge): all outputs 0; state IDLE; phase 0; sync FFs 0;
//    debounced buttons 0; debounce counters 0. Reset mid-frame aborts with no
//    further o_load.
//  - Input sync: every input bit passes through 2 FFs. i_port/i_link_pow are used
//    after sync; i_button feeds the debouncers after sync.
//  - Debounce, per bit:
//    - counter clears whenever sync == debounced;
//    - otherwise it increments;
//    - on reaching DEBOUNCE_CYCLES the debounced value takes sync and the counter clears;
//    - a glitch shorter than DEBOUNCE_CYCLES never changes debounced.
//    - Debouncers run in all states.
//  - FSM states:
//    - IDLE: o_load=0, phase held 0. i_enable=1 -> ARM.
//    - ARM: one cycle; capture snapshot (sync port/link_pow, debounced buttons) -> RUN, phase 0.
//    - RUN: o_load=1 when phase==0, else 0; phase increments each cycle.
//      At phase FRAME_CYCLES-1:
//      - i_enable=1: capture new snapshot, phase -> 0 (next cycle carries o_load);
//      - i_enable=0: -> IDLE, snapshot held.
//  - Stop is graceful: i_enable may drop at any phase; the current frame always
//    completes (no truncated frame).
//  - Re-enable during the final frame behaves as continuous streaming.
//  - Snapshot outputs change only on capture cycles, so they are constant from
//    the o_load cycle through the end of that frame.
//  - Latency:
//    - pin change -> snapshot: 2 sync cycles + wait for the next capture;
//    - i_enable rise (seen in IDLE) -> first o_load: 2 cycles.
//  - o_frame_cnt increments on each o_load cycle; 2^CNT_W-1 wraps to 0. Held in IDLE.
//  - o_active = (state != IDLE).
// STRUCTURE
//  - Shared package breakout_pkg:
//    - FRAME_CYCLES default;
//    - PORT_W=8, BTN_W=6, POW_W=4;
//    - FSM state encoding ST_IDLE/ST_ARM/ST_RUN (2-bit localparams).
//  - Sub-module btn_debounce (one bit: sync FFs, counter, debounced reg),
//    generate-instantiated BTN_W times.
//  - The FSM, phase counter, snapshot and frame counter stay in this module.
// TESTING
//  - Reset: hold i_rst 3 cycles with inputs toggling -> all outputs 0,
//    o_load never asserts.
//  - Start: raise i_enable with i_port=8'hA5, i_link_pow=4'h9 stable >= 3 cycles
//    -> o_load 2 cycles later, then every 5 cycles; o_port=8'hA5,
//    o_link_pow=4'h9 at each load; o_frame_cnt 1,2,3...
//  - Coherence: change i_port 8'h00->8'hFF at phase 2
//    -> o_port stays 8'h00 through phase 4; 8'hFF at the first o_load where the
//    change was synced before capture.
//  - Debounce (DEBOUNCE_CYCLES=8): pulse i_button[3] high for 5 cycles -> o_button
//    stays 0; hold high 20 cycles -> o_button[3]=1 at the first capture after
//    2+8 cycles.
//  - Stop: drop i_enable at phase 1 -> phases 2..4 complete, no further o_load,
//    o_active=0 after phase 4; snapshot and o_frame_cnt held. Re-raise -> restart
//    with 2-cycle latency.
//  - Wrap and abort: CNT_W=4, stream 17 frames -> o_frame_cnt 15->0->1.
//    Assert i_rst at phase 3 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/breakout_pkg.sv
// breakout_pkg: shared widths, defaults and FSM encoding for the breakout frame controller
package breakout_pkg;
    localparam int FRAME_CYCLES_DEF = 5;
    localparam int PORT_W = 8;
    localparam int BTN_W = 6;
    localparam int POW_W = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-FF synchronizer plus stable-count debouncer for one button bit
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_db
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic s0, s1;
    logic [CW-1:0] cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            cnt <= '0;
            o_db <= 1'b0;
        end else begin
            s0 <= i_raw;
            s1 <= s0;
            if (s1 == o_db)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                o_db <= s1;
                cnt <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/breakout_frame_ctrl.sv
// breakout_frame_ctrl: frame strobe, input sync/debounce and per-frame snapshot for the DDR serializer
module breakout_frame_ctrl
    import breakout_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [PORT_W-1:0] i_port,
    input  logic [BTN_W-1:0]  i_button,
    input  logic [POW_W-1:0]  i_link_pow,
    output logic              o_load,
    output logic [2:0]        o_phase,
    output logic [PORT_W-1:0] o_port,
    output logic [BTN_W-1:0]  o_button,
    output logic [POW_W-1:0]  o_link_pow,
    output logic              o_active,
    output logic [CNT_W-1:0]  o_frame_cnt
);
    localparam logic [2:0] LAST = 3'(FRAME_CYCLES - 1);
    state_t state, state_nx;
    logic [2:0] phase, phase_nx;
    logic [PORT_W-1:0] port_s0, port_s1;
    logic [POW_W-1:0] pow_s0, pow_s1;
    logic [BTN_W-1:0] btn_db;
    logic last, capture;

    for (genvar g = 0; g < BTN_W; g++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .i_clk(i_clk),
            .i_rst(i_rst),
            .i_raw(i_button[g]),
            .o_db (btn_db[g])
        );
    end

    // Enable is only sampled at the frame end, so a stop never truncates a frame
    always_comb begin
        last = state == ST_RUN && phase == LAST;
        capture = state == ST_ARM || (last && i_enable);
        state_nx = capture ? ST_RUN
                 : (state == ST_IDLE && i_enable) ? ST_ARM
                 : (state == ST_RUN && !last) ? ST_RUN : ST_IDLE;
        phase_nx = (state == ST_RUN && !last) ? phase + 3'd1 : 3'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            phase <= 3'd0;
            port_s0 <= '0;
            port_s1 <= '0;
            pow_s0 <= '0;
            pow_s1 <= '0;
            o_port <= '0;
            o_button <= '0;
            o_link_pow <= '0;
            o_frame_cnt <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            port_s0 <= i_port;
            port_s1 <= port_s0;
            pow_s0 <= i_link_pow;
            pow_s1 <= pow_s0;
            // Count moves with the snapshot so it is valid during the load cycle
            if (capture) begin
                o_port <= port_s1;
                o_button <= btn_db;
                o_link_pow <= pow_s1;
                o_frame_cnt <= o_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign o_load = state == ST_RUN && phase == 3'd0;
    assign o_phase = phase;
    assign o_active = state != ST_IDLE;
endmodule

// File: tb/tb_breakout_frame_ctrl.sv
// tb_breakout_frame_ctrl: randomized stimulus checked every cycle against a frame-level reference model
module tb_breakout_frame_ctrl;
    localparam int FC = 5;
    localparam int DEB = 8;
    localparam int CW = 4;
    logic i_clk = 1'b0;
    logic i_rst, i_enable;
    logic [7:0] i_port;
    logic [5:0] i_button;
    logic [3:0] i_link_pow;
    logic o_load, o_active;
    logic [2:0] o_phase;
    logic [7:0] o_port;
    logic [5:0] o_button;
    logic [3:0] o_link_pow;
    logic [CW-1:0] o_frame_cnt;
    int n_chk = 0, n_err = 0;
    int m_mode, m_phase, m_cnt;
    logic [7:0] m_port;
    logic [5:0] m_btn, m_db;
    logic [3:0] m_pow;
    logic [7:0] dly_port [2];
    logic [5:0] dly_btn [2];
    logic [3:0] dly_pow [2];
    logic [5:0] win [DEB];

    always #5 i_clk = ~i_clk;

    breakout_frame_ctrl #(.FRAME_CYCLES(FC), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_enable(i_enable),
        .i_port(i_port),
        .i_button(i_button),
        .i_link_pow(i_link_pow),
        .o_load(o_load),
        .o_phase(o_phase),
        .o_port(o_port),
        .o_button(o_button),
        .o_link_pow(o_link_pow),
        .o_active(o_active),
        .o_frame_cnt(o_frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Mode 0 idle, 1 arming, 2 streaming; pins reach the logic two edges late
    task automatic model_edge();
        logic cap;
        logic all_diff;
        if (i_rst) begin
            m_mode = 0; m_phase = 0; m_cnt = 0;
            m_port = 0; m_btn = 0; m_pow = 0; m_db = 0;
            dly_port = '{default: '0};
            dly_btn = '{default: '0};
            dly_pow = '{default: '0};
            win = '{default: '0};
            return;
        end
        cap = 1'b0;
        if (m_mode == 0) begin
            if (i_enable) m_mode = 1;
        end else if (m_mode == 1) begin
            cap = 1'b1; m_mode = 2; m_phase = 0;
        end else if (m_phase == FC - 1) begin
            m_phase = 0;
            if (i_enable) cap = 1'b1; else m_mode = 0;
        end else
            m_phase++;
        if (cap) begin
            m_port = dly_port[1];
            m_btn = m_db;
            m_pow = dly_pow[1];
            m_cnt = (m_cnt + 1) % (1 << CW);
        end
        for (int j = DEB - 1; j > 0; j--) win[j] = win[j-1];
        win[0] = dly_btn[1];
        for (int b = 0; b < 6; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) if (win[j][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) m_db[b] = ~m_db[b];
        end
        dly_port[1] = dly_port[0]; dly_port[0] = i_port;
        dly_btn[1] = dly_btn[0]; dly_btn[0] = i_button;
        dly_pow[1] = dly_pow[0]; dly_pow[0] = i_link_pow;
    endtask

    task automatic tick();
        model_edge();
        @(negedge i_clk);
        chk("load", 32'(o_load), 32'(m_mode == 2 && m_phase == 0));
        chk("phase", 32'(o_phase), 32'(m_phase));
        chk("active", 32'(o_active), 32'(m_mode != 0));
        chk("port", 32'(o_port), 32'(m_port));
        chk("button", 32'(o_button), 32'(m_btn));
        chk("link_pow", 32'(o_link_pow), 32'(m_pow));
        chk("frame_cnt", 32'(o_frame_cnt), 32'(m_cnt));
    endtask

    initial begin
        i_rst = 1'b1; i_enable = 1'b0; i_port = '0; i_button = '0; i_link_pow = '0;
        tick();
        repeat (3) begin
            i_enable = 1'($urandom); i_port = 8'($urandom);
            i_button = 6'($urandom); i_link_pow = 4'($urandom);
            tick();
        end
        i_rst = 1'b0; i_enable = 1'b0; i_port = 8'hA5; i_link_pow = 4'h9; i_button = '0;
        repeat (3) tick();
        i_enable = 1'b1;
        repeat (40) tick();
        repeat (5000) begin
            if ($urandom_range(0, 7) == 0) i_port = 8'($urandom);
            if ($urandom_range(0, 7) == 0) i_link_pow = 4'($urandom);
            if ($urandom_range(0, 5) == 0) i_button = i_button ^ 6'(1 << $urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) i_enable = ~i_enable;
            i_rst = $urandom_range(0, 699) == 0;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
